// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: a one-hot T1..T6 ring plus the IR opcode decode into the control word.
// Optional SAP1_EARLY_END_EN: variable-length machine cycle that skips idle states back to T1.
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       pc_incr,
    output logic       pc_enable,
    output logic       mar_load,
    output logic       ram_enable,
    output logic       ir_load,
    output logic       ir_enable,
    output logic       a_load,
    output logic       a_enable,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_enable,
    output logic       out_load,
    output logic       halted,
    output logic [5:0] t_state
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    ring_t state;

`ifdef SAP1_EARLY_END_EN
    logic op_known;
    assign op_known = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_OUT) || (opcode == OP_HLT);
`endif

    // Ring advance; HLT freezes the ring in T4 until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            case (state)
                T1: state <= T2;
                T2: state <= T3;
`ifdef SAP1_EARLY_END_EN
                T3: state <= op_known ? T4 : T1;
                T4: begin
                    if (opcode == OP_HLT)
                        halted <= 1'b1;
                    else if (opcode == OP_OUT)
                        state <= T1;
                    else
                        state <= T5;
                end
                T5: state <= (opcode == OP_LDA) ? T1 : T6;
`else
                T3: state <= T4;
                T4: begin
                    if (opcode == OP_HLT)
                        halted <= 1'b1;
                    else
                        state <= T5;
                end
                T5: state <= T6;
`endif
                T6: state <= T1;
                default: state <= T1;
            endcase
        end
    end

    assign t_state = state;

    always_comb begin
        pc_incr    = 1'b0;
        pc_enable  = 1'b0;
        mar_load   = 1'b0;
        ram_enable = 1'b0;
        ir_load    = 1'b0;
        ir_enable  = 1'b0;
        a_load     = 1'b0;
        a_enable   = 1'b0;
        b_load     = 1'b0;
        alu_sub    = 1'b0;
        alu_enable = 1'b0;
        out_load   = 1'b0;
        if (!halted) begin
            case (state)
                T1: begin
                    pc_enable = 1'b1;
                    mar_load  = 1'b1;
                end
                T2: pc_incr = 1'b1;
                T3: begin
                    ram_enable = 1'b1;
                    ir_load    = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ir_enable = 1'b1;
                        mar_load  = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_enable = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_enable = 1'b1;
                        a_load     = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ram_enable = 1'b1;
                        b_load     = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_enable = 1'b1;
                        a_load     = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed self-checking bench for sap1_controller; honours SAP1_EARLY_END_EN for cycle-length expectations.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic pc_incr, pc_enable, mar_load, ram_enable, ir_load, ir_enable;
    logic a_load, a_enable, b_load, alu_sub, alu_enable, out_load, halted;
    logic [5:0]  t_state;
    logic [11:0] ctrl;
    int checks = 0;
    int errors = 0;
    bit monitor_on = 1'b0;

    localparam logic [11:0] PI = 12'h800, PE = 12'h400, ML = 12'h200, RE = 12'h100;
    localparam logic [11:0] IL = 12'h080, IE = 12'h040, AL = 12'h020, AEN = 12'h010;
    localparam logic [11:0] BL = 12'h008, AS = 12'h004, ALE = 12'h002, OL = 12'h001;

    sap1_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .pc_incr(pc_incr), .pc_enable(pc_enable), .mar_load(mar_load),
        .ram_enable(ram_enable), .ir_load(ir_load), .ir_enable(ir_enable),
        .a_load(a_load), .a_enable(a_enable), .b_load(b_load), .alu_sub(alu_sub),
        .alu_enable(alu_enable), .out_load(out_load), .halted(halted), .t_state(t_state)
    );

    assign ctrl = {pc_incr, pc_enable, mar_load, ram_enable, ir_load, ir_enable,
                   a_load, a_enable, b_load, alu_sub, alu_enable, out_load};

    always #5 clk = ~clk;

    // Structural invariants sampled mid-cycle on every cycle after the first reset.
    always @(negedge clk) begin
        if (monitor_on) begin
            checks++;
            if (!$onehot(t_state)) begin
                errors++;
                $display("[TB] FAIL onehot: t_state=%b", t_state);
            end
            checks++;
            if ($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) > 1) begin
                errors++;
                $display("[TB] FAIL bus_enable: ctrl=%h has multiple enables", ctrl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [3:0] op);
        reset = 1'b1;
        opcode = op;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        monitor_on = 1'b1;
        checks++;
        if ({halted, t_state, ctrl} !== {1'b0, 6'b000001, PE | ML}) begin
            errors++;
            $display("[TB] FAIL reset_t1: got h=%b t=%b c=%h want h=0 t=000001 c=%h", halted, t_state, ctrl, PE | ML);
        end
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b000010, PI}) begin
            errors++;
            $display("[TB] FAIL reset_t2: got t=%b c=%h want t=000010 c=%h", t_state, ctrl, PI);
        end
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b000100, RE | IL}) begin
            errors++;
            $display("[TB] FAIL reset_t3: got t=%b c=%h want t=000100 c=%h", t_state, ctrl, RE | IL);
        end
    endtask

    task automatic test_lda();
        restart(4'h0);
        repeat (3) tick();
        checks++;
        if ({t_state, ctrl} !== {6'b001000, IE | ML}) begin
            errors++;
            $display("[TB] FAIL lda_t4: got t=%b c=%h want t=001000 c=%h", t_state, ctrl, IE | ML);
        end
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b010000, RE | AL}) begin
            errors++;
            $display("[TB] FAIL lda_t5: got t=%b c=%h want t=010000 c=%h", t_state, ctrl, RE | AL);
        end
`ifndef SAP1_EARLY_END_EN
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b100000, 12'h000}) begin
            errors++;
            $display("[TB] FAIL lda_t6: got t=%b c=%h want t=100000 c=000", t_state, ctrl);
        end
`endif
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b000001, PE | ML}) begin
            errors++;
            $display("[TB] FAIL lda_wrap: got t=%b c=%h want t=000001 c=%h", t_state, ctrl, PE | ML);
        end
    endtask

    task automatic test_add_sub();
        restart(4'h2);
        repeat (3) tick();
        checks++;
        if ({t_state, ctrl} !== {6'b001000, IE | ML}) begin
            errors++;
            $display("[TB] FAIL sub_t4: got t=%b c=%h want t=001000 c=%h", t_state, ctrl, IE | ML);
        end
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b010000, RE | BL}) begin
            errors++;
            $display("[TB] FAIL sub_t5: got t=%b c=%h want t=010000 c=%h", t_state, ctrl, RE | BL);
        end
        tick();
        checks++;
        if ({t_state, ctrl} !== {6'b100000, ALE | AL | AS}) begin
            errors++;
            $display("[TB] FAIL sub_t6: got t=%b c=%h want t=100000 c=%h", t_state, ctrl, ALE | AL | AS);
        end
        tick();
        opcode = 4'h1;
        repeat (5) tick();
        checks++;
        if ({t_state, ctrl} !== {6'b100000, ALE | AL}) begin
            errors++;
            $display("[TB] FAIL add_t6: got t=%b c=%h want t=100000 c=%h", t_state, ctrl, ALE | AL);
        end
    endtask

    task automatic test_halt();
        restart(4'hF);
        repeat (3) tick();
        checks++;
        if ({halted, t_state, ctrl} !== {1'b0, 6'b001000, 12'h000}) begin
            errors++;
            $display("[TB] FAIL hlt_t4: got h=%b t=%b c=%h want h=0 t=001000 c=000", halted, t_state, ctrl);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) opcode = 4'h0;
            if (i == 12) opcode = 4'h1;
            checks++;
            if ({halted, t_state, ctrl} !== {1'b1, 6'b001000, 12'h000}) begin
                errors++;
                $display("[TB] FAIL hlt_hold%0d: got h=%b t=%b c=%h want h=1 t=001000 c=000", i, halted, t_state, ctrl);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({halted, t_state, ctrl} !== {1'b0, 6'b000001, PE | ML}) begin
            errors++;
            $display("[TB] FAIL hlt_reset: got h=%b t=%b c=%h want h=0 t=000001 c=%h", halted, t_state, ctrl, PE | ML);
        end
    endtask

    task automatic test_reset_mid();
        restart(4'h1);
        repeat (4) tick();
        checks++;
        if ({t_state, b_load} !== {6'b010000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_t5: got t=%b b_load=%b want t=010000 b_load=1", t_state, b_load);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({t_state, b_load, ctrl} !== {6'b000001, 1'b0, PE | ML}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got t=%b b_load=%b c=%h want t=000001 b_load=0 c=%h", t_state, b_load, ctrl, PE | ML);
        end
    endtask

    task automatic test_out_period();
        int period;
        int expected;
`ifdef SAP1_EARLY_END_EN
        expected = 4;
`else
        expected = 6;
`endif
        restart(4'hE);
        repeat (3) tick();
        checks++;
        if ({t_state, ctrl} !== {6'b001000, AEN | OL}) begin
            errors++;
            $display("[TB] FAIL out_t4: got t=%b c=%h want t=001000 c=%h", t_state, ctrl, AEN | OL);
        end
        tick();
        checks++;
        if (t_state !== ((expected == 4) ? 6'b000001 : 6'b010000)) begin
            errors++;
            $display("[TB] FAIL out_after_t4: got t=%b want %b", t_state, (expected == 4) ? 6'b000001 : 6'b010000);
        end
        period = 1;
        while (t_state !== 6'b001000 && period < 12) begin
            tick();
            period++;
        end
        checks++;
        if (period !== expected) begin
            errors++;
            $display("[TB] FAIL out_period: got %0d cycles want %0d", period, expected);
        end
    endtask

    task automatic test_nop();
        restart(4'h5);
        repeat (3) tick();
        checks++;
`ifdef SAP1_EARLY_END_EN
        if ({t_state, ctrl} !== {6'b000001, PE | ML}) begin
            errors++;
            $display("[TB] FAIL nop_skip: got t=%b c=%h want t=000001 c=%h", t_state, ctrl, PE | ML);
        end
`else
        if ({t_state, ctrl} !== {6'b001000, 12'h000}) begin
            errors++;
            $display("[TB] FAIL nop_t4: got t=%b c=%h want t=001000 c=000", t_state, ctrl);
        end
        repeat (2) tick();
        checks++;
        if ({t_state, ctrl} !== {6'b100000, 12'h000}) begin
            errors++;
            $display("[TB] FAIL nop_t6: got t=%b c=%h want t=100000 c=000", t_state, ctrl);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_halt();
        test_reset_mid();
        test_out_period();
        test_nop();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
